cmd_frame_uart_tx: RTL and testbench

- Downstream stage of the command-string generator.
- Accepts a packed multi-byte ASCII servo command frame, e.g. "#000P1500T1000!" with the first character in the least-significant byte, and serialises it byte by byte onto a UART TX line (8N1, LSB first).
- Pulses trans_done once per completed frame; the generator advances its command pointer on that pulse.

---
 rtl/cmd_frame_uart_tx_if.sv | 32 +++
 rtl/cmd_frame_uart_tx.sv | 151 +++++++++++++++
 tb/tb_cmd_frame_uart_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_uart_tx_if.sv
// Frame-to-UART handshake bundle: frame request from the command generator,
// serial line and progress status back from the transmitter.
interface cmd_frame_uart_tx_if #(
    parameter int BYTE_NUM = 15
);
    localparam int IDX_W = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;

    logic                    send_en;
    logic [8*BYTE_NUM-1:0]   instr;
    logic                    uart_txd;
    logic                    busy;
    logic                    trans_done;
    logic [IDX_W-1:0]        byte_idx;

    modport master (
        output send_en,
        output instr,
        input  uart_txd,
        input  busy,
        input  trans_done,
        input  byte_idx
    );

    modport slave (
        input  send_en,
        input  instr,
        output uart_txd,
        output busy,
        output trans_done,
        output byte_idx
    );
endinterface

// File: rtl/cmd_frame_uart_tx.sv
// Serialises a packed multi-byte command frame (byte 0 first) as 8N1 UART.
// Define UART_PARITY_EN to insert an even-parity bit after each data byte.
module cmd_frame_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int BYTE_NUM = 15
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    cmd_frame_uart_tx_if.slave bus
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W    = (BYTE_NUM > 1) ? $clog2(BYTE_NUM) : 1;
    localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTE_NUM - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                r_state;
    logic [BW-1:0]         r_baud_cnt;
    logic [2:0]            r_bit_cnt;
    logic [IDX_W-1:0]      r_byte_idx;
    logic                  r_txd;
    logic                  r_trans_done;
    logic [8*BYTE_NUM-1:0] r_frame;

    state_t                w_state_nxt;
    logic [BW-1:0]         w_baud_nxt;
    logic [2:0]            w_bit_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_txd_nxt;
    logic                  w_done_nxt;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_wrap;
    logic [7:0]            w_cur_byte;

    assign w_wrap     = (r_baud_cnt == BAUD_LAST);
    // The frame register shifts down one byte per completed byte, so the
    // byte on the line is always the low byte.
    assign w_cur_byte = r_frame[7:0];

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_idx_nxt   = r_byte_idx;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;

        if (r_state == IDLE) begin
            w_baud_nxt = '0;
            w_bit_nxt  = '0;
            w_idx_nxt  = '0;
            if (bus.send_en) begin
                w_state_nxt = START;
                w_load      = 1'b1;
            end
        end else begin
            w_baud_nxt = w_wrap ? '0 : r_baud_cnt + 1'b1;
            if (w_wrap) begin
                case (r_state)
                    START: begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end
                    DATA: begin
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_cnt + 3'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: w_state_nxt = STOP;
`endif
                    STOP: begin
                        if (r_byte_idx == IDX_LAST) begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = '0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = START;
                            w_idx_nxt   = r_byte_idx + 1'b1;
                            w_shift     = 1'b1;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
            end
        end

        // Line level is registered from the next state to keep uart_txd glitch-free.
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = w_cur_byte[w_bit_nxt];
`ifdef UART_PARITY_EN
            PARITY:  w_txd_nxt = ^w_cur_byte;
`endif
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_baud_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_byte_idx   <= '0;
            r_txd        <= 1'b1;
            r_trans_done <= 1'b0;
        end else begin
            r_baud_cnt   <= w_baud_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_byte_idx   <= w_idx_nxt;
            r_txd        <= w_txd_nxt;
            r_trans_done <= w_done_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_load) begin
            r_frame <= bus.instr;
        end else if (w_shift) begin
            r_frame <= r_frame >> 8;
        end
    end

    assign bus.uart_txd   = r_txd;
    assign bus.busy       = (r_state != IDLE);
    assign bus.trans_done = r_trans_done;
    assign bus.byte_idx   = r_byte_idx;
endmodule

// File: tb/tb_cmd_frame_uart_tx.sv
// Scoreboard bench: expected bytes are queued at request time and compared
// against bytes decoded from uart_txd by a cycle-counting line monitor.
module tb_cmd_frame_uart_tx;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BYTE_NUM = 15;
`ifdef UART_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME_CYC = BYTE_NUM * BITS * BAUD_DIV;

    logic sys_clk;
    logic sys_rst_n;

    cmd_frame_uart_tx_if #(.BYTE_NUM(BYTE_NUM)) bus ();

    cmd_frame_uart_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .BYTE_NUM(BYTE_NUM)
    ) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [8*BYTE_NUM-1:0] pack(input string s);
        logic [8*BYTE_NUM-1:0] v;
        v = '0;
        for (int i = 0; i < BYTE_NUM; i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic push_frame(input string s);
        for (int i = 0; i < BYTE_NUM; i++) exp_q.push_back(s[i]);
    endtask

    always @(posedge sys_clk) cyc++;

    // Line monitor: samples every cycle, takes each bit at its first cycle and
    // flags any change within the bit period.
    logic        mon_active = 1'b0;
    int          mon_cnt    = 0;
    logic [10:0] rx_bits;
    logic        hold_bad   = 1'b0;
    logic        prev_busy  = 1'b0;
    logic        prev_done  = 1'b0;
    int          frame_start = 0;

    always @(negedge sys_clk) begin
        logic [7:0] rx_byte;
        logic [7:0] exp_byte;
        if (!sys_rst_n) begin
            mon_active = 1'b0;
            hold_bad   = 1'b0;
            prev_busy  = 1'b0;
            prev_done  = 1'b0;
            exp_q.delete();
        end else begin
            if (bus.busy && !prev_busy) frame_start = cyc;
            if (bus.trans_done) begin
                done_cnt++;
                check_val("done_time", cyc - frame_start, FRAME_CYC);
                check_val("done_width", {31'd0, prev_done}, 0);
                check_val("done_idle", {bus.busy, bus.uart_txd, bus.byte_idx}, {1'b0, 1'b1, 4'd0});
            end
            prev_busy = bus.busy;
            prev_done = bus.trans_done;

            if (!mon_active && bus.uart_txd == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                hold_bad   = 1'b0;
            end
            if (mon_active) begin
                if (mon_cnt % BAUD_DIV == 0) rx_bits[mon_cnt / BAUD_DIV] = bus.uart_txd;
                else if (bus.uart_txd !== rx_bits[mon_cnt / BAUD_DIV]) hold_bad = 1'b1;
                if (mon_cnt == BITS * BAUD_DIV - 1) begin
                    mon_active = 1'b0;
                    rx_byte = rx_bits[8:1];
                    check_val("bit_hold", {31'd0, hold_bad}, 0);
                    check_val("start_stop", {rx_bits[0], rx_bits[BITS-1]}, 2'b01);
                    check_val("sb_nonempty", (exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp_byte = exp_q.pop_front();
                        check_val("byte", rx_byte, exp_byte);
`ifdef UART_PARITY_EN
                        check_val("parity", {31'd0, rx_bits[9]}, {31'd0, ^exp_byte});
`endif
                    end
                end
                mon_cnt++;
            end
        end
    end

    task automatic wait_done(input int max_cyc);
        int start = done_cnt;
        int i = 0;
        while (done_cnt == start && i < max_cyc) begin
            @(posedge sys_clk);
            i++;
        end
        check_val("done_seen", (done_cnt != start), 1);
    endtask

    localparam string S0 = "#000P1500T1000!";
    localparam string S1 = "#001P2500T1000!";

    initial begin
        int d0;
        sys_rst_n   = 1'b0;
        bus.send_en = 1'b0;
        bus.instr   = pack(S0);
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("rst_state", {bus.uart_txd, bus.busy, bus.trans_done, bus.byte_idx},
                  {1'b1, 1'b0, 1'b0, 4'd0});
        sys_rst_n = 1'b1;

        // Single frame; second request mid-frame is ignored; instr change after accept
        @(posedge sys_clk); #1;
        d0 = done_cnt;
        bus.send_en = 1'b1;
        push_frame(S0);
        @(posedge sys_clk); #1;
        bus.send_en = 1'b0;
        bus.instr   = pack(S1);
        check_val("accept_start", {bus.busy, bus.uart_txd}, 2'b10);
        repeat (299) @(posedge sys_clk);
        #1 bus.send_en = 1'b1;
        @(posedge sys_clk); #1;
        bus.send_en = 1'b0;
        wait_done(2 * FRAME_CYC);
        repeat (FRAME_CYC + 100) @(posedge sys_clk);
        #1;
        check_val("single_done", done_cnt - d0, 1);
        check_val("idle_after", {bus.busy, bus.uart_txd}, 2'b01);
        check_val("sb_drain1", exp_q.size(), 0);

        // send_en held high: back-to-back frames
        d0 = done_cnt;
        bus.instr   = pack(S0);
        bus.send_en = 1'b1;
        push_frame(S0);
        @(posedge sys_clk); #1;
        bus.instr = pack(S1);
        wait_done(2 * FRAME_CYC);
        #1;
        bus.send_en = 1'b0;
        push_frame(S1);
        check_val("b2b_start", {bus.busy, bus.uart_txd}, 2'b10);
        wait_done(2 * FRAME_CYC);
        repeat (20) @(posedge sys_clk);
        #1;
        check_val("b2b_done", done_cnt - d0, 2);
        check_val("sb_drain2", exp_q.size(), 0);

        // Reset during byte 5 aborts the frame
        d0 = done_cnt;
        bus.instr   = pack(S0);
        bus.send_en = 1'b1;
        push_frame(S0);
        @(posedge sys_clk); #1;
        bus.send_en = 1'b0;
        repeat (549) @(posedge sys_clk);
        #1;
        check_val("mid_byte_idx", bus.byte_idx, 5);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        check_val("abort_state", {bus.uart_txd, bus.busy, bus.byte_idx}, {1'b1, 1'b0, 4'd0});
        sys_rst_n = 1'b1;
        repeat (FRAME_CYC + 100) @(posedge sys_clk);
        #1;
        check_val("abort_no_done", done_cnt - d0, 0);
        bus.instr   = pack(S1);
        bus.send_en = 1'b1;
        push_frame(S1);
        @(posedge sys_clk); #1;
        bus.send_en = 1'b0;
        wait_done(2 * FRAME_CYC);
        repeat (5) @(posedge sys_clk);
        #1;
        check_val("sb_drain3", exp_q.size(), 0);

        // Reset wins over send_en at the same edge
        sys_rst_n   = 1'b0;
        bus.send_en = 1'b1;
        @(posedge sys_clk); #1;
        check_val("rst_prio", {bus.busy, bus.uart_txd}, 2'b01);
        sys_rst_n   = 1'b1;
        bus.send_en = 1'b0;
        @(posedge sys_clk); #1;
        check_val("rst_prio_hold", {bus.busy, bus.uart_txd}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
